control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Control unit driving the single-cycle microcontroller datapath: decodes opcode (instr[15:10]) and z,
//  drives s_inc, s_inm, we3, wez, op. Adds run/step/stop/halt sequencing, gating all state-changing
//  strobes (incl. new datapath PC load enable pc_en), plus a retired-instruction counter. Sits beside
//  the datapath at top level; one instruction executes per cycle while executing.
// PARAMETERS
//  CNT_W           16  width of retired-instruction counter
//  START_ON_RESET  0   1: reset enters RUN directly; 0: reset enters IDLE
// PORTS
//  clk      in   1      clock, all state updates on rising edge
//  reset    in   1      synchronous, active-high reset
//  opcode   in   6      instr[15:10] from datapath
//  z        in   1      registered zero flag from datapath
//  start    in   1      pulse: IDLE -> RUN
//  step     in   1      pulse: IDLE -> execute exactly one instruction
//  stop     in   1      pulse: RUN -> IDLE after current instruction
//  s_inc    out  1      1: PC <= PC+1; 0: PC <= instr[9:0]
//  s_inm    out  1      1: ALU A = immediate instr[11:4]; 0: A = rd1
//  we3      out  1      register file write enable
//  wez      out  1      zero-flag load enable
//  op       out  3      ALU operation (3'b000 = pass A)
//  pc_en    out  1      PC load enable
//  running  out  1      state is RUN or STEP
//  halted   out  1      state is HALT
//  illegal  out  1      sticky: illegal opcode fetched while executing
//  retired  out  CNT_W  count of executed instructions
// BEHAVIOUR
//  Synchronous, active-high reset clears everything in one edge:
//   state=IDLE (RUN if START_ON_RESET), illegal=0, retired=0. Reset overrides all other inputs, even mid-run/HALT.
//  Decode (combinational from opcode, z; valid only in exec states RUN/STEP):
//   1xxxxx  ALU : op=opcode[4:2], s_inm=0, we3=1, wez=1, s_inc=1, pc_en=1
//   0000xx  LI  : op=000, s_inm=1, we3=1, wez=0, s_inc=1, pc_en=1
//   000100  J   : we3=0, wez=0, s_inc=0, pc_en=1
//   000101  JZ  : we3=0, wez=0, s_inc=~z, pc_en=1
//   000110  JNZ : we3=0, wez=0, s_inc=z,  pc_en=1
//   000111  HALT: we3=0, wez=0, pc_en=0
//   001xxx, 01xxxx: illegal -> we3=0, wez=0, pc_en=0
//  Gated default (IDLE, HALT, HALT opcode, illegal): we3=0, wez=0, pc_en=0, s_inc=1, s_inm=0, op=000.
//  FSM (next state at clk edge):
//   IDLE: start -> RUN; else step -> STEP; start&step -> RUN. No execution in IDLE.
//   RUN : HALT opcode or illegal -> HALT; else stop -> IDLE (current instr still executes); else RUN.
//   STEP: executes current instr; HALT/illegal -> HALT, else IDLE. start/stop/step ignored.
//   HALT: terminal; start/step/stop ignored; only reset leaves.
//  illegal set on the edge ending an exec cycle with illegal opcode; sticky until reset.
//  retired += 1 (mod 2^CNT_W, wraps to 0) on each exec cycle with legal non-HALT opcode; one-cycle latency.
//  running/halted are registered state decodes; running=1 in RUN and STEP.
//  Jump-taken decision uses z as presented in the same cycle (flag written by previous instruction).
// TESTING
//  reset, start, opcode=6'b101000 -> op=010, we3=1, wez=1, s_inc=1, pc_en=1; retired 0->1 next edge
//  RUN, opcode=000101: z=0 -> s_inc=1, pc_en=1; z=1 -> s_inc=0; we3=wez=0 both cases; JNZ inverse
//  IDLE, step pulse, opcode=000000 -> one cycle s_inm=1, we3=1, op=000; then IDLE, pc_en=0, retired=1
//  RUN, opcode=000111 -> pc_en=0 that cycle, halted=1 next; start/step ignored; reset -> IDLE, halted=0
//  RUN, opcode=010000 -> we3=wez=pc_en=0, illegal=1 and halted=1 next; retired unchanged
//  CNT_W=4: 16 ALU instrs in RUN -> retired wraps 15->0; reset mid-run -> retired=0, state IDLE, strobes 0

Source files
------------

// File: rtl/control_unit_if.sv
// Handshake bundle between the control unit and the datapath/sequencer.
// The master drives the fetched opcode, flag and run controls; the slave returns the strobes.
interface control_unit_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       opcode;
  logic             z;
  logic             start;
  logic             step;
  logic             stop;
  logic             s_inc;
  logic             s_inm;
  logic             we3;
  logic             wez;
  logic [2:0]       op;
  logic             pc_en;
  logic             running;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    output opcode, z, start, step, stop,
    input  s_inc, s_inm, we3, wez, op, pc_en, running, halted, illegal, retired
  );

  modport slave (
    input  opcode, z, start, step, stop,
    output s_inc, s_inm, we3, wez, op, pc_en, running, halted, illegal, retired
  );
endinterface

// File: rtl/control_unit.sv
// Single-cycle microcontroller control unit: opcode decode gated by a run/step/stop/halt
// sequencer, a sticky illegal-opcode flag and a retired-instruction counter.
module control_unit #(
  parameter int CNT_W          = 16,
  parameter bit START_ON_RESET = 1'b0
) (
  input logic           clk,
  input logic           reset,
  control_unit_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_HALT} state_t;

  state_t           r_state;
  logic             r_running;
  logic             r_halted;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retired;

  logic       w_exec;
  logic       w_s_inc;
  logic       w_s_inm;
  logic       w_we3;
  logic       w_wez;
  logic [2:0] w_op;
  logic       w_pc_en;
  logic       w_halt_op;
  logic       w_ill_op;
  logic       w_retire;
  state_t     w_state_nxt;

  assign w_exec = (r_state == S_RUN) || (r_state == S_STEP);

  // Decode; anything not executing falls back to the safe gated default.
  always_comb begin
    w_s_inc   = 1'b1;
    w_s_inm   = 1'b0;
    w_we3     = 1'b0;
    w_wez     = 1'b0;
    w_op      = 3'b000;
    w_pc_en   = 1'b0;
    w_halt_op = 1'b0;
    w_ill_op  = 1'b0;
    w_retire  = 1'b0;
    if (w_exec) begin
      if (bus.opcode[5]) begin
        w_op     = bus.opcode[4:2];
        w_we3    = 1'b1;
        w_wez    = 1'b1;
        w_pc_en  = 1'b1;
        w_retire = 1'b1;
      end else if (bus.opcode[4:3] != 2'b00) begin
        w_ill_op = 1'b1;
      end else if (!bus.opcode[2]) begin
        w_s_inm  = 1'b1;
        w_we3    = 1'b1;
        w_pc_en  = 1'b1;
        w_retire = 1'b1;
      end else begin
        case (bus.opcode[1:0])
          2'b00:   begin w_s_inc = 1'b0;     w_pc_en = 1'b1; w_retire = 1'b1; end
          2'b01:   begin w_s_inc = ~bus.z;   w_pc_en = 1'b1; w_retire = 1'b1; end
          2'b10:   begin w_s_inc = bus.z;    w_pc_en = 1'b1; w_retire = 1'b1; end
          default: w_halt_op = 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start)     w_state_nxt = S_RUN;
        else if (bus.step) w_state_nxt = S_STEP;
      end
      S_RUN: begin
        if (w_halt_op || w_ill_op) w_state_nxt = S_HALT;
        else if (bus.stop)         w_state_nxt = S_IDLE;
      end
      S_STEP:  w_state_nxt = (w_halt_op || w_ill_op) ? S_HALT : S_IDLE;
      default: w_state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= START_ON_RESET ? S_RUN : S_IDLE;
      r_running <= START_ON_RESET;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == S_RUN) || (w_state_nxt == S_STEP);
      r_halted  <= (w_state_nxt == S_HALT);
      if (w_ill_op) r_illegal <= 1'b1;
      if (w_retire) r_retired <= r_retired + 1'b1;
    end
  end

  assign bus.s_inc   = w_s_inc;
  assign bus.s_inm   = w_s_inm;
  assign bus.we3     = w_we3;
  assign bus.wez     = w_wez;
  assign bus.op      = w_op;
  assign bus.pc_en   = w_pc_en;
  assign bus.running = r_running;
  assign bus.halted  = r_halted;
  assign bus.illegal = r_illegal;
  assign bus.retired = r_retired;
endmodule

// File: tb/tb_control_unit.sv
// Randomized scoreboard bench for control_unit (CNT_W=4 so the counter wrap is reachable).
module tb_control_unit;
  localparam int CW = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;

  logic clk = 1'b0;
  logic reset;
  control_unit_if #(.CNT_W(CW)) bus ();

  control_unit #(.CNT_W(CW), .START_ON_RESET(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference state, kept as plain integers.
  int mode;
  bit m_ill;
  int m_ret;

  logic [14:0] exp_q[$];
  int          cyc_q[$];
  int          n_chk = 0;
  int          bad   = 0;
  int          cyc_n = 0;

  // Behavioural model: returns expected outputs for the current cycle and advances the model.
  task automatic model_step(input bit r, input bit st, input bit sp, input bit so,
                            input int opc, input bit zz, output logic [14:0] e);
    bit exec, halt_op, ill_op, legal;
    bit s_inc, s_inm, we3, wez, pc_en;
    int alu_op;
    exec    = (mode == M_RUN) || (mode == M_STEP);
    halt_op = (opc == 7);
    ill_op  = (opc >= 8) && (opc < 32);
    legal   = !halt_op && !ill_op;
    s_inc = 1; s_inm = 0; we3 = 0; wez = 0; pc_en = 0; alu_op = 0;
    if (exec) begin
      if (opc >= 32)     begin alu_op = (opc / 4) % 8; we3 = 1; wez = 1; pc_en = 1; end
      else if (opc < 4)  begin s_inm = 1; we3 = 1; pc_en = 1; end
      else if (opc == 4) begin s_inc = 0; pc_en = 1; end
      else if (opc == 5) begin s_inc = !zz; pc_en = 1; end
      else if (opc == 6) begin s_inc = zz; pc_en = 1; end
    end
    e = {s_inc, s_inm, we3, wez, alu_op[2:0], pc_en,
         (mode == M_RUN) || (mode == M_STEP), mode == M_HALT, m_ill, m_ret[CW-1:0]};
    if (r) begin
      mode = M_IDLE; m_ill = 0; m_ret = 0;
    end else if (exec) begin
      if (!legal) begin
        if (ill_op) m_ill = 1;
        mode = M_HALT;
      end else begin
        m_ret = (m_ret + 1) % (1 << CW);
        if (mode == M_STEP || so) mode = M_IDLE;
      end
    end else if (mode == M_IDLE) begin
      if (st)      mode = M_RUN;
      else if (sp) mode = M_STEP;
    end
  endtask

  task automatic cyc(input bit r, input bit st, input bit sp, input bit so,
                     input int opc, input bit zz, input bit chk);
    logic [14:0] e;
    logic [5:0]  o6;
    @(posedge clk);
    #1;
    o6 = opc[5:0];
    reset = r; bus.start = st; bus.step = sp; bus.stop = so;
    bus.opcode = o6; bus.z = zz;
    model_step(r, st, sp, so, opc, zz, e);
    if (chk) begin
      exp_q.push_back(e);
      cyc_q.push_back(cyc_n);
    end
    cyc_n++;
  endtask

  function automatic int rand_op(input bit hazard);
    int r;
    r = $urandom_range(0, 99);
    if (r < 45) return 32 + $urandom_range(0, 31);
    if (r < 65) return $urandom_range(0, 3);
    if (r < 90 || !hazard) return $urandom_range(4, 6);
    if (r < 95) return 7;
    return 8 + $urandom_range(0, 23);
  endfunction

  // Monitor: compares every presented cycle against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [14:0] e, a;
      int c;
      e = exp_q.pop_front();
      c = cyc_q.pop_front();
      a = {bus.s_inc, bus.s_inm, bus.we3, bus.wez, bus.op, bus.pc_en,
           bus.running, bus.halted, bus.illegal, bus.retired};
      n_chk++;
      if (a !== e) begin
        bad++;
        $display("FAIL cyc%0d {s_inc,s_inm,we3,wez,op,pc_en,run,halt,ill,ret} got=%b want=%b",
                 c, a, e);
      end
    end
  end

  initial begin
    mode = M_IDLE; m_ill = 0; m_ret = 0;
    reset = 1'b1; bus.start = 0; bus.step = 0; bus.stop = 0; bus.opcode = '0; bus.z = 0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 6'b101000, 0, 1);
    // ALU after start
    cyc(0, 1, 0, 0, 6'b101000, 0, 1);
    cyc(0, 0, 0, 0, 6'b101000, 0, 1);
    // JZ / JNZ with both flag values
    cyc(0, 0, 0, 0, 6'b000101, 0, 1);
    cyc(0, 0, 0, 0, 6'b000101, 1, 1);
    cyc(0, 0, 0, 0, 6'b000110, 0, 1);
    cyc(0, 0, 0, 0, 6'b000110, 1, 1);
    cyc(0, 0, 0, 0, 6'b000100, 1, 1);
    cyc(0, 0, 0, 1, 6'b100100, 0, 1);
    // single step of LI
    cyc(0, 0, 0, 0, 6'b000000, 0, 1);
    cyc(0, 0, 1, 0, 6'b000000, 0, 1);
    cyc(0, 1, 1, 1, 6'b000000, 0, 1);
    cyc(0, 0, 0, 0, 6'b000000, 0, 1);
    // counter wrap
    cyc(0, 1, 0, 0, 6'b111111, 0, 1);
    for (int i = 0; i < 18; i++) cyc(0, 0, 0, 0, 32 + i, i[0], 1);
    // HALT opcode, then ignored controls, then reset
    cyc(0, 0, 0, 0, 6'b000111, 0, 1);
    cyc(0, 1, 1, 1, 6'b101000, 0, 1);
    cyc(0, 1, 0, 0, 6'b000000, 0, 1);
    cyc(1, 0, 0, 0, 6'b000000, 0, 1);
    cyc(0, 0, 0, 0, 6'b000000, 0, 1);
    // illegal opcode in RUN
    cyc(0, 1, 0, 0, 6'b010000, 0, 1);
    cyc(0, 0, 0, 0, 6'b010000, 0, 1);
    cyc(0, 0, 1, 0, 6'b101000, 0, 1);
    cyc(0, 0, 0, 0, 6'b101000, 0, 1);
    // illegal via STEP, then reset mid-run
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 6'b001011, 0, 1);
    cyc(0, 0, 0, 0, 6'b001011, 0, 1);
    cyc(0, 0, 0, 0, 6'b001011, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 6'b110000, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 6'b110000, 0, 1);
    cyc(1, 0, 0, 0, 6'b110000, 0, 1);
    cyc(0, 0, 0, 0, 6'b110000, 0, 1);
    // randomized episodes
    for (int ep = 0; ep < 20; ep++) begin
      cyc(1, 0, 0, 0, rand_op(0), $urandom_range(0, 1), 1);
      for (int i = 0; i < 60; i++) begin
        cyc($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 15) == 0, rand_op(ep % 3 != 0), $urandom_range(0, 1), 1);
      end
    end
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_chk, bad);
    $finish;
  end
endmodule
